// File: rtl/dllp_tx_scheduler.sv
// ---------------------------------------------------------------------------
// dllp_tx_scheduler
//
// Purpose:
//   Link-side transmit scheduler for the data link layer. One AXI-Stream
//   egress is shared between TLP frames from the retry buffer and locally
//   generated Ack/Nak and UpdateFC DLLPs. Arbitration happens only at frame
//   boundaries, in a single IDLE decision cycle. DLLP beats carry the 4-byte
//   body only. The framing/CRC16 stage downstream appends the CRC16.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   s_axis_tlp_*            TLP ingress (tdata/tkeep/tvalid/tlast/tuser, tready out)
//   m_axis_*                egress to framing; tuser[0]=1 marks a DLLP,
//                           tuser[3:1] carries TLP tuser[3:1] (0 for DLLPs)
//   ack_nack_i              1 = Nak, 0 = Ack
//   ack_nack_vld_i          one-cycle Ack/Nak request strobe
//   ack_seq_num_i           AckNak_Seq_Num of the request
//   tx_fc_ph_i/pd_i/nph_i/npd_i  advertised credits, sampled when an
//                           UpdateFC beat is loaded
//
// Parameters:
//   DATA_WIDTH      egress/ingress width; only 32 is supported
//   KEEP_WIDTH      DATA_WIDTH/8
//   USER_WIDTH      sideband width; bit0 is the DLLP marker
//   FC_TIMER_CYCLES UpdateFC refresh period in clk cycles (>= 4)
//   MAX_DLLP_BURST  consecutive DLLPs allowed while a TLP is waiting
// ---------------------------------------------------------------------------
module dllp_tx_scheduler #(
    parameter int DATA_WIDTH      = 32,
    parameter int KEEP_WIDTH      = 4,
    parameter int USER_WIDTH      = 4,
    parameter int FC_TIMER_CYCLES = 1024,
    parameter int MAX_DLLP_BURST  = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic [DATA_WIDTH-1:0] s_axis_tlp_tdata_i,
    input  logic [KEEP_WIDTH-1:0] s_axis_tlp_tkeep_i,
    input  logic                  s_axis_tlp_tvalid_i,
    input  logic                  s_axis_tlp_tlast_i,
    input  logic [USER_WIDTH-1:0] s_axis_tlp_tuser_i,
    output logic                  s_axis_tlp_tready_o,

    output logic [DATA_WIDTH-1:0] m_axis_tdata_o,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep_o,
    output logic                  m_axis_tvalid_o,
    output logic                  m_axis_tlast_o,
    output logic [USER_WIDTH-1:0] m_axis_tuser_o,
    input  logic                  m_axis_tready_i,

    input  logic                  ack_nack_i,
    input  logic                  ack_nack_vld_i,
    input  logic [11:0]           ack_seq_num_i,

    input  logic [7:0]            tx_fc_ph_i,
    input  logic [11:0]           tx_fc_pd_i,
    input  logic [7:0]            tx_fc_nph_i,
    input  logic [11:0]           tx_fc_npd_i
);

    // -----------------------------------------------------------------------
    // Constants
    // -----------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_TLP  = 2'd1;
    localparam logic [1:0] ST_DLLP = 2'd2;

    // Which pending source the registered DLLP beat came from.
    localparam logic [1:0] K_ACKNAK = 2'd0;
    localparam logic [1:0] K_FCP    = 2'd1;
    localparam logic [1:0] K_FCNP   = 2'd2;

    // DLLP type bytes, VC0.
    localparam logic [7:0] TYPE_ACK  = 8'h00;
    localparam logic [7:0] TYPE_NAK  = 8'h10;
    localparam logic [7:0] TYPE_FCP  = 8'h80;
    localparam logic [7:0] TYPE_FCNP = 8'h90;

    localparam int TMR_W   = (FC_TIMER_CYCLES > 1) ? $clog2(FC_TIMER_CYCLES) : 1;
    localparam int BURST_W = $clog2(MAX_DLLP_BURST + 1);

    localparam logic [TMR_W-1:0]   FC_RELOAD = TMR_W'(FC_TIMER_CYCLES - 1);
    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_DLLP_BURST);

    localparam logic [USER_WIDTH-1:0] USER_DLLP = USER_WIDTH'(1);

    // -----------------------------------------------------------------------
    // DLLP body builders; byte0 (first on the wire) sits in [7:0].
    // -----------------------------------------------------------------------
    function automatic logic [31:0] acknak_body(input logic nak, input logic [11:0] seq);
        return {seq[7:0], 4'h0, seq[11:8], 8'h00, (nak ? TYPE_NAK : TYPE_ACK)};
    endfunction

    function automatic logic [31:0] fc_body(input logic [7:0]  fc_type,
                                            input logic [7:0]  hdr,
                                            input logic [11:0] dat);
        return {dat[7:0], hdr[1:0], 2'b00, dat[11:8], 2'b00, hdr[7:2], fc_type};
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [1:0]            state_q,     state_d;
    logic [1:0]            kind_q,      kind_d;
    logic [DATA_WIDTH-1:0] dllp_data_q, dllp_data_d;
    logic [BURST_W-1:0]    burst_q,     burst_d;
    logic [TMR_W-1:0]      fc_timer_q,  fc_timer_d;
    logic                  fcp_pend_q,  fcp_pend_d;
    logic                  fcnp_pend_q, fcnp_pend_d;
    logic                  an_pend_q,   an_pend_d;
    logic                  an_nak_q,    an_nak_d;
    logic [11:0]           an_seq_q,    an_seq_d;
    // Set when an Ack/Nak request lands after the current Ack/Nak beat was
    // loaded, so that request survives the beat's acceptance.
    logic                  an_upd_q,    an_upd_d;

    logic unused_tuser0;
    assign unused_tuser0 = s_axis_tlp_tuser_i[0];

    // -----------------------------------------------------------------------
    // Decision terms
    // -----------------------------------------------------------------------
    logic in_idle, in_dllp;
    logic tlp_forced;
    logic load_an, load_fcp, load_fcnp;
    logic dllp_accept, an_accept, fcp_accept, fcnp_accept;
    logic an_hold;
    logic timer_expire;

    assign in_idle = (state_q == ST_IDLE);
    assign in_dllp = (state_q == ST_DLLP);

    // A waiting TLP wins once the DLLP burst allowance is used up.
    assign tlp_forced = s_axis_tlp_tvalid_i && (burst_q == BURST_MAX);

    assign load_an   = in_idle && !tlp_forced && an_pend_q;
    assign load_fcp  = in_idle && !tlp_forced && !an_pend_q && fcp_pend_q;
    assign load_fcnp = in_idle && !tlp_forced && !an_pend_q && !fcp_pend_q && fcnp_pend_q;

    assign dllp_accept = in_dllp && m_axis_tready_i;
    assign an_accept   = dllp_accept && (kind_q == K_ACKNAK);
    assign fcp_accept  = dllp_accept && (kind_q == K_FCP);
    assign fcnp_accept = dllp_accept && (kind_q == K_FCNP);

    // The latched Ack/Nak content is being loaded or is already on the egress.
    assign an_hold = load_an || (in_dllp && (kind_q == K_ACKNAK));

    assign timer_expire = (fc_timer_q == '0);

    // -----------------------------------------------------------------------
    // Main FSM, burst counter and DLLP beat register
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable written here gets a default first, so no
        // path leaves it unassigned and no latch is inferred.
        state_d     = state_q;
        kind_d      = kind_q;
        dllp_data_d = dllp_data_q;
        burst_d     = burst_q;

        case (state_q)
            ST_IDLE: begin
                if (!s_axis_tlp_tvalid_i) begin
                    burst_d = '0;
                end
                if (load_an) begin
                    state_d     = ST_DLLP;
                    kind_d      = K_ACKNAK;
                    dllp_data_d = DATA_WIDTH'(acknak_body(an_nak_q, an_seq_q));
                end else if (load_fcp) begin
                    state_d     = ST_DLLP;
                    kind_d      = K_FCP;
                    dllp_data_d = DATA_WIDTH'(fc_body(TYPE_FCP, tx_fc_ph_i, tx_fc_pd_i));
                end else if (load_fcnp) begin
                    state_d     = ST_DLLP;
                    kind_d      = K_FCNP;
                    dllp_data_d = DATA_WIDTH'(fc_body(TYPE_FCNP, tx_fc_nph_i, tx_fc_npd_i));
                end else if (s_axis_tlp_tvalid_i) begin
                    state_d = ST_TLP;
                    burst_d = '0;
                end
            end

            ST_TLP: begin
                if (s_axis_tlp_tvalid_i && m_axis_tready_i && s_axis_tlp_tlast_i) begin
                    state_d = ST_IDLE;
                end
            end

            ST_DLLP: begin
                if (m_axis_tready_i) begin
                    state_d = ST_IDLE;
                    // Only DLLPs sent while a TLP is waiting count toward the burst.
                    if (!s_axis_tlp_tvalid_i) begin
                        burst_d = '0;
                    end else if (burst_q != BURST_MAX) begin
                        burst_d = burst_q + BURST_W'(1);
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Ack/Nak request latch
    // -----------------------------------------------------------------------
    always_comb begin
        logic fresh;
        an_pend_d = an_pend_q;
        an_nak_d  = an_nak_q;
        an_seq_d  = an_seq_q;
        an_upd_d  = an_upd_q;
        fresh     = 1'b0;

        if (an_accept) begin
            an_pend_d = an_upd_q;
            an_upd_d  = 1'b0;
        end

        if (ack_nack_vld_i) begin
            an_pend_d = 1'b1;
            an_seq_d  = ack_seq_num_i;
            // A request starts a new entry when nothing unsent is pending:
            // the latch is empty, its beat leaves this cycle, or it is the
            // first request since the beat was loaded. Otherwise a Nak
            // overrides an Ack but an Ack never downgrades a pending Nak.
            fresh    = !an_pend_q || an_accept || (an_hold && !an_upd_q);
            an_nak_d = fresh ? ack_nack_i : (an_nak_q | ack_nack_i);
            if (an_hold && !an_accept) begin
                an_upd_d = 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // UpdateFC refresh timer and pending flags; a new expiry re-arms a flag
    // even in the cycle its DLLP is accepted.
    // -----------------------------------------------------------------------
    always_comb begin
        fc_timer_d  = timer_expire ? FC_RELOAD : (fc_timer_q - TMR_W'(1));
        fcp_pend_d  = (fcp_pend_q  && !fcp_accept)  || timer_expire;
        fcnp_pend_d = (fcnp_pend_q && !fcnp_accept) || timer_expire;
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            kind_q      <= K_ACKNAK;
            dllp_data_q <= '0;
            burst_q     <= '0;
            fc_timer_q  <= FC_RELOAD;
            fcp_pend_q  <= 1'b0;
            fcnp_pend_q <= 1'b0;
            an_pend_q   <= 1'b0;
            an_nak_q    <= 1'b0;
            an_seq_q    <= '0;
            an_upd_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q     <= state_d;
            kind_q      <= kind_d;
            dllp_data_q <= dllp_data_d;
            burst_q     <= burst_d;
            fc_timer_q  <= fc_timer_d;
            fcp_pend_q  <= fcp_pend_d;
            fcnp_pend_q <= fcnp_pend_d;
            an_pend_q   <= an_pend_d;
            an_nak_q    <= an_nak_d;
            an_seq_q    <= an_seq_d;
            an_upd_q    <= an_upd_d;
        end
    end

    // -----------------------------------------------------------------------
    // Egress / ingress handshake. Outputs decode from state, so an
    // asynchronous reset drops them immediately, even mid-frame.
    // -----------------------------------------------------------------------
    always_comb begin
        m_axis_tdata_o      = '0;
        m_axis_tkeep_o      = '0;
        m_axis_tvalid_o     = 1'b0;
        m_axis_tlast_o      = 1'b0;
        m_axis_tuser_o      = '0;
        s_axis_tlp_tready_o = 1'b0;

        case (state_q)
            ST_TLP: begin
                m_axis_tdata_o      = s_axis_tlp_tdata_i;
                m_axis_tkeep_o      = s_axis_tlp_tkeep_i;
                m_axis_tvalid_o     = s_axis_tlp_tvalid_i;
                m_axis_tlast_o      = s_axis_tlp_tlast_i;
                m_axis_tuser_o      = {s_axis_tlp_tuser_i[USER_WIDTH-1:1], 1'b0};
                s_axis_tlp_tready_o = m_axis_tready_i;
            end
            ST_DLLP: begin
                m_axis_tdata_o  = dllp_data_q;
                m_axis_tkeep_o  = {KEEP_WIDTH{1'b1}};
                m_axis_tvalid_o = 1'b1;
                m_axis_tlast_o  = 1'b1;
                m_axis_tuser_o  = USER_DLLP;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_dllp_tx_scheduler.sv
// ---------------------------------------------------------------------------
// tb_dllp_tx_scheduler
//
// Directed-vector bench for dllp_tx_scheduler. Each test pushes the egress
// beats it expects onto a scoreboard queue; an independent monitor pops and
// compares every accepted egress beat. Inputs change 1 time unit after the
// rising edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_dllp_tx_scheduler;

    localparam int FC_CYC = 1024;
    localparam int BURST  = 4;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        logic [3:0]  user;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [31:0] s_tdata  = '0;
    logic [3:0]  s_tkeep  = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tlast  = 1'b0;
    logic [3:0]  s_tuser  = '0;
    logic        s_tready;

    logic [31:0] m_tdata;
    logic [3:0]  m_tkeep;
    logic        m_tvalid;
    logic        m_tlast;
    logic [3:0]  m_tuser;
    logic        m_tready = 1'b0;

    logic        ack_nack     = 1'b0;
    logic        ack_nack_vld = 1'b0;
    logic [11:0] ack_seq      = '0;
    logic [7:0]  fc_ph  = '0;
    logic [11:0] fc_pd  = '0;
    logic [7:0]  fc_nph = '0;
    logic [11:0] fc_npd = '0;

    beat_t sb_q[$];
    int    n_checks = 0;
    int    n_errors = 0;
    int    cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dllp_tx_scheduler #(
        .DATA_WIDTH      (32),
        .KEEP_WIDTH      (4),
        .USER_WIDTH      (4),
        .FC_TIMER_CYCLES (FC_CYC),
        .MAX_DLLP_BURST  (BURST)
    ) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .s_axis_tlp_tdata_i  (s_tdata),
        .s_axis_tlp_tkeep_i  (s_tkeep),
        .s_axis_tlp_tvalid_i (s_tvalid),
        .s_axis_tlp_tlast_i  (s_tlast),
        .s_axis_tlp_tuser_i  (s_tuser),
        .s_axis_tlp_tready_o (s_tready),
        .m_axis_tdata_o      (m_tdata),
        .m_axis_tkeep_o      (m_tkeep),
        .m_axis_tvalid_o     (m_tvalid),
        .m_axis_tlast_o      (m_tlast),
        .m_axis_tuser_o      (m_tuser),
        .m_axis_tready_i     (m_tready),
        .ack_nack_i          (ack_nack),
        .ack_nack_vld_i      (ack_nack_vld),
        .ack_seq_num_i       (ack_seq),
        .tx_fc_ph_i          (fc_ph),
        .tx_fc_pd_i          (fc_pd),
        .tx_fc_nph_i         (fc_nph),
        .tx_fc_npd_i         (fc_npd)
    );

    // -----------------------------------------------------------------------
    // Helpers
    // -----------------------------------------------------------------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic beat_t dllp_beat(input logic [31:0] d);
        beat_t b;
        b.data = d; b.keep = 4'hF; b.last = 1'b1; b.user = 4'b0001;
        return b;
    endfunction

    function automatic beat_t tlp_beat(input logic [31:0] d, input logic [3:0] k,
                                       input logic l, input logic [3:0] u_out);
        beat_t b;
        b.data = d; b.keep = k; b.last = l; b.user = u_out;
        return b;
    endfunction

    task automatic idle_inputs();
        s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0; s_tuser = '0;
        ack_nack_vld = 1'b0; ack_nack = 1'b0; ack_seq = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        sb_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_ack(input logic nak, input logic [11:0] seq);
        ack_nack = nak; ack_seq = seq; ack_nack_vld = 1'b1;
        @(posedge clk);
        #1;
        ack_nack_vld = 1'b0;
    endtask

    // Presents one TLP beat and waits (bounded) for it to be accepted;
    // acc returns the cycle stamp of the accepting edge.
    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l,
                             input logic [3:0] u, output int acc);
        bit hs;
        s_tdata = d; s_tkeep = k; s_tlast = l; s_tuser = u; s_tvalid = 1'b1;
        acc = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            hs = s_tready;
            @(posedge clk);
            #1;
            if (hs) begin
                acc = cyc;
                break;
            end
        end
        if (acc < 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL tlp_beat_timeout: got no tready in 300 cycles, expected accept of 0x%h", d);
        end
        if (l) s_tvalid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 300 && sb_q.size() != 0; i++) @(posedge clk);
        repeat (10) @(posedge clk);
        check(name, sb_q.size(), 0);
        #1;
    endtask

    // -----------------------------------------------------------------------
    // Monitor: compare every accepted egress beat against the scoreboard.
    // -----------------------------------------------------------------------
    initial begin : monitor
        beat_t got;
        beat_t exp;
        forever begin
            @(negedge clk);
            if (!rst && m_tvalid && m_tready) begin
                got = {m_tdata, m_tkeep, m_tlast, m_tuser};
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_beat: got data 0x%h user 0x%h, expected no beat",
                             m_tdata, m_tuser);
                end else begin
                    exp = sb_q.pop_front();
                    check("egress_beat", 64'(got), 64'(exp));
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: got no end of test, expected finish within 1 ms");
        $fatal(1, "watchdog expired");
    end

    // -----------------------------------------------------------------------
    // Stimulus
    // -----------------------------------------------------------------------
    initial begin : stim
        int lat;
        int c0, c1, c2, c3;
        bit found;

        // ---- 1: reset values, then first UpdateFC after the timer period --
        rst = 1'b1;
        s_tvalid = 1'b1; s_tdata = 32'hDEADBEEF; s_tkeep = 4'hF; s_tlast = 1'b1;
        m_tready = 1'b1; ack_nack_vld = 1'b1; ack_seq = 12'hFFF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {m_tdata, m_tkeep, m_tvalid, m_tlast, m_tuser, s_tready}, '0);
        idle_inputs();
        sb_q.push_back(dllp_beat(32'h0000_0080));
        sb_q.push_back(dllp_beat(32'h0000_0090));
        rst = 1'b0;
        // Timer starts at FC_CYC-1 and expires FC_CYC edges after release;
        // the IDLE load edge follows, so tvalid is first seen after edge FC_CYC+1.
        lat = 0;
        for (int n = 1; n <= FC_CYC + 100; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (m_tvalid) begin
                lat = n;
                break;
            end
        end
        check("fc_first_latency", lat, FC_CYC + 1);
        wait_drain("t1_drain");

        // ---- 2: single Ack on an idle egress ------------------------------
        do_reset();
        m_tready = 1'b1;
        sb_q.push_back(dllp_beat(32'h2301_0000));
        pulse_ack(1'b0, 12'h123);
        wait_drain("t2_drain");

        // ---- 3: Ack then Nak before the grant -> one Nak ------------------
        do_reset();
        m_tready = 1'b0;
        sb_q.push_back(tlp_beat(32'hCAFE_F00D, 4'hF, 1'b1, 4'b0000));
        sb_q.push_back(dllp_beat(32'h0700_0010));
        fork
            send_beat(32'hCAFE_F00D, 4'hF, 1'b1, 4'b0000, c0);
            begin
                repeat (3) begin @(posedge clk); #1; end
                pulse_ack(1'b0, 12'h005);
                pulse_ack(1'b1, 12'h007);
                m_tready = 1'b1;
            end
        join
        wait_drain("t3_drain");

        // ---- 4: Ack requested mid-frame follows the frame -----------------
        do_reset();
        m_tready = 1'b1;
        sb_q.push_back(tlp_beat(32'h1000_0001, 4'hF, 1'b0, 4'b1010));
        sb_q.push_back(tlp_beat(32'h2000_0002, 4'hF, 1'b0, 4'b1010));
        sb_q.push_back(tlp_beat(32'h3000_0003, 4'h3, 1'b1, 4'b1010));
        sb_q.push_back(dllp_beat(32'h5604_0000));
        send_beat(32'h1000_0001, 4'hF, 1'b0, 4'b1011, c0);
        fork
            pulse_ack(1'b0, 12'h456);
            send_beat(32'h2000_0002, 4'hF, 1'b0, 4'b1011, c1);
        join
        send_beat(32'h3000_0003, 4'h3, 1'b1, 4'b1011, c2);
        check("t4_beat1_contiguous", c1 - c0, 1);
        check("t4_beat2_contiguous", c2 - c1, 1);
        wait_drain("t4_drain");

        // ---- 5: UpdateFC bodies, beat held stable under backpressure ------
        do_reset();
        m_tready = 1'b0;
        fc_ph = 8'h41; fc_pd = 12'h123; fc_nph = 8'h22; fc_npd = 12'h456;
        sb_q.push_back(dllp_beat(32'h2341_1080));
        sb_q.push_back(dllp_beat(32'h5684_0890));
        found = 1'b0;
        for (int i = 0; i < FC_CYC + 100; i++) begin
            @(negedge clk);
            if (m_tvalid) begin
                found = 1'b1;
                break;
            end
        end
        check("t5_fcp_appears", found, 1);
        for (int k = 0; k < 5; k++) begin
            check("t5_fcp_held", {m_tvalid, m_tlast, m_tdata}, {1'b1, 1'b1, 32'h2341_1080});
            @(posedge clk);
            #1;
            // Credits move while the beat waits; the loaded body must not.
            if (k == 0) fc_ph = 8'hFF;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        m_tready = 1'b1;
        wait_drain("t5_drain");
        fc_ph = '0; fc_pd = '0; fc_nph = '0; fc_npd = '0;

        // ---- 6: burst limit lets a waiting TLP through after 4 DLLPs ------
        do_reset();
        m_tready = 1'b1;
        for (int i = 0; i < BURST; i++) sb_q.push_back(dllp_beat(32'hAB00_0000));
        sb_q.push_back(tlp_beat(32'h1111_0000, 4'hF, 1'b0, 4'b0010));
        sb_q.push_back(tlp_beat(32'h2222_0001, 4'h1, 1'b1, 4'b0010));
        sb_q.push_back(dllp_beat(32'hAB00_0000));
        ack_nack = 1'b0; ack_seq = 12'h0AB; ack_nack_vld = 1'b1;
        @(posedge clk);
        #1;
        send_beat(32'h1111_0000, 4'hF, 1'b0, 4'b0010, c3);
        send_beat(32'h2222_0001, 4'h1, 1'b1, 4'b0011, c3);
        ack_nack_vld = 1'b0;
        wait_drain("t6_drain");

        // ---- 7: reset mid-frame drops the egress at once ------------------
        do_reset();
        m_tready = 1'b0;
        s_tdata = 32'h5A5A_5A5A; s_tkeep = 4'hF; s_tlast = 1'b1; s_tuser = '0; s_tvalid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("t7_stalled_frame", {m_tvalid, m_tdata}, {1'b1, 32'h5A5A_5A5A});
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("t7_reset_drop", {m_tvalid, s_tready, m_tdata}, '0);
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
